// File: rtl/ddr_dqs_lpbk_chk.sv
// DQS driver loopback checker: drives a pattern on the complement data input,
// resynchronizes the true/complement loopback legs and counts mismatches.
module ddr_dqs_lpbk_chk #(
  parameter int unsigned LAT_WIDTH = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [1:0]           i_mode,
  input  logic [LAT_WIDTH-1:0] i_lat,
  input  logic [CNT_WIDTH-1:0] i_num,
  output logic                 o_d_n,
  output logic                 o_oe,
  input  logic                 i_lpbk_t,
  input  logic                 i_lpbk_c,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_pair_err,
  output logic [CNT_WIDTH-1:0] o_err_cnt
);

  localparam int unsigned DL_DEPTH = (1 << LAT_WIDTH) + 2;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_mode;
  logic [LAT_WIDTH-1:0]   r_lat;
  logic [CNT_WIDTH-1:0]   r_num;
  logic [CNT_WIDTH-1:0]   r_cmp;
  logic [LAT_WIDTH:0]     r_fill;
  logic [6:0]             r_lfsr;
  logic                   r_tog;
  logic [DL_DEPTH-1:0]    r_dl;
  logic [1:0]             r_sync_t, r_sync_c;
  logic                   r_d_n, r_done, r_err, r_pair_err;
  logic [CNT_WIDTH-1:0]   r_err_cnt;

  logic                   w_accept, w_run, w_run_nxt;
  logic                   w_fill_last, w_cmp_last;
  logic [CNT_WIDTH-1:0]   w_cmp_inc;
  logic [6:0]             w_lfsr_step;
  logic                   w_g, w_e, w_st, w_sc, w_mis, w_pair;
  logic [LAT_WIDTH:0]     w_tap;

  assign w_accept    = (r_state == S_IDLE) && i_start;
  assign w_run       = (r_state == S_FILL) || (r_state == S_CHECK);
  assign w_run_nxt   = (w_state_nxt == S_FILL) || (w_state_nxt == S_CHECK);
  assign w_fill_last = (r_fill == ({1'b0, r_lat} + (LAT_WIDTH+1)'(1)));
  assign w_cmp_inc   = r_cmp + CNT_WIDTH'(1);
  assign w_cmp_last  = (r_num != '0) && (w_cmp_inc == r_num);
  assign w_lfsr_step = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};

  // The delay line is fed with the bit being launched this edge, so the bit
  // launched at start sits at index lat+2 on the first CHECK edge.
  assign w_tap  = {1'b0, r_lat} + (LAT_WIDTH+1)'(2);
  assign w_e    = r_dl[w_tap];
  assign w_st   = r_sync_t[1];
  assign w_sc   = r_sync_c[1];
  assign w_mis  = (w_st != w_e) || (w_sc != ~w_e);
  assign w_pair = (w_st == w_sc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_FILL;
      S_FILL:  begin
        if (i_stop)           w_state_nxt = S_DONE;
        else if (w_fill_last) w_state_nxt = S_CHECK;
      end
      S_CHECK: if (i_stop || w_cmp_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = w_run;
    o_oe   = w_run;
  end

  always_comb begin
    w_g = 1'b0;
    if (w_accept) begin
      w_g = (i_mode != 2'd0);
    end else if (w_run) begin
      case (r_mode)
        2'd0:    w_g = 1'b0;
        2'd1:    w_g = 1'b1;
        2'd2:    w_g = ~r_tog;
        default: w_g = w_lfsr_step[6];
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= '0;
      r_lat      <= '0;
      r_num      <= '0;
      r_cmp      <= '0;
      r_fill     <= '0;
      r_lfsr     <= 7'h7F;
      r_tog      <= 1'b0;
      r_dl       <= '0;
      r_sync_t   <= '0;
      r_sync_c   <= '0;
      r_d_n      <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_pair_err <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_sync_t <= {r_sync_t[0], i_lpbk_t};
      r_sync_c <= {r_sync_c[0], i_lpbk_c};
      r_dl     <= {r_dl[DL_DEPTH-2:0], w_g};
      r_d_n    <= w_run_nxt ? ~w_g : 1'b1;

      if (w_accept) begin
        r_mode     <= i_mode;
        r_lat      <= i_lat;
        r_num      <= i_num;
        r_cmp      <= '0;
        r_fill     <= '0;
        r_lfsr     <= 7'h7F;
        r_tog      <= 1'b1;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_pair_err <= 1'b0;
        r_err_cnt  <= '0;
      end else if (w_run) begin
        r_lfsr <= w_lfsr_step;
        r_tog  <= ~r_tog;
        if (r_state == S_FILL) r_fill <= r_fill + (LAT_WIDTH+1)'(1);
        if (r_state == S_CHECK) begin
          r_cmp <= w_cmp_inc;
          if (w_mis) begin
            r_err <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
          end
          if (w_pair) r_pair_err <= 1'b1;
        end
        if (w_state_nxt == S_DONE) r_done <= 1'b1;
      end
    end
  end

  assign o_d_n      = r_d_n;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_pair_err = r_pair_err;
  assign o_err_cnt  = r_err_cnt;

endmodule
